// File: rtl/dmem_map_pkg.sv
// Data-memory map shared by the CPU/stream arbiter: image region and
// device-register window, plus the stream reader state encoding.
package dmem_map_pkg;

    localparam int unsigned IMG_BASE   = 0;
    localparam int unsigned IMG_BYTES  = 152100;
    localparam int unsigned DREG_BASE  = 152100;
    localparam int unsigned DREG_WORDS = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } stream_state_t;

    // Last legal byte-past-end of a stream that scans the image region.
    function automatic logic [63:0] img_end();
        return 64'(IMG_BASE) + 64'(IMG_BYTES);
    endfunction

endpackage

// File: rtl/dmem_stream_arbiter_if.sv
// Bundle of CPU, DataMemory and stream-control signals around the arbiter.
// slave = arbiter view, master = surrounding system view.
interface dmem_stream_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 18
);
    // CPU load/store path
    logic              cpu_en;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wd;
    logic [31:0]       cpu_rd;
    logic              cpu_stall;
    // DataMemory port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;
    // stream control and byte output
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport slave (
        input  cpu_en, cpu_we, cpu_addr, cpu_wd, mem_rd,
        input  start, abort, base_addr, length, s_ready,
        output cpu_rd, cpu_stall, mem_we, mem_addr, mem_wd,
        output s_data, s_valid, busy, done, cfg_err
    );

    modport master (
        output cpu_en, cpu_we, cpu_addr, cpu_wd, mem_rd,
        output start, abort, base_addr, length, s_ready,
        input  cpu_rd, cpu_stall, mem_we, mem_addr, mem_wd,
        input  s_data, s_valid, busy, done, cfg_err
    );

endinterface

// File: rtl/dmem_starve_arb.sv
// Grant logic for the shared DataMemory port. The CPU wins conflicts until
// the stream has lost STARVE_LIMIT in a row; the next conflict goes to the stream.
module dmem_starve_arb #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_en,
    input  logic stream_want,
    output logic grant_cpu,
    output logic grant_str
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          force_str;

    assign force_str = stream_want && (starve_cnt == LIMIT);
    assign grant_cpu = cpu_en && !force_str;
    assign grant_str = stream_want && !grant_cpu;

    // Count consecutive conflicts the CPU won; any other cycle restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_cpu && stream_want) begin
            if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/dmem_stream_arbiter.sv
// Shares the DataMemory port between the CPU and a byte-stream reader that
// scans the image region out to a VGA/UART consumer over valid/ready.
module dmem_stream_arbiter
    import dmem_map_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int LEN_W        = 18,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_stream_arbiter_if.slave  bus
);
    stream_state_t     state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic [7:0]        s_data_q;
    logic              s_valid_q;
    logic              done_q;
    logic              cfg_err_q;

    logic              stream_want;
    logic              grant_cpu;
    logic              grant_str;
    logic [ADDR_W:0]   span_end;
    logic              cfg_ok;

    // One extra bit so base+length cannot wrap past the image end check.
    assign span_end = {1'b0, bus.base_addr} + (ADDR_W+1)'(bus.length);
    assign cfg_ok   = span_end <= (ADDR_W+1)'(img_end());

    // Fetch only when the output register is empty or being drained this cycle.
    assign stream_want = (state == ST_RUN) && (!s_valid_q || bus.s_ready);

    dmem_starve_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .cpu_en      (bus.cpu_en),
        .stream_want (stream_want),
        .grant_cpu   (grant_cpu),
        .grant_str   (grant_str)
    );

    assign bus.cpu_stall = bus.cpu_en && !grant_cpu;
    assign bus.mem_we    = grant_cpu && bus.cpu_we;
    assign bus.mem_addr  = grant_cpu ? bus.cpu_addr : ptr;
    assign bus.mem_wd    = bus.cpu_wd;
    assign bus.cpu_rd    = bus.mem_rd;

    assign bus.s_data    = s_data_q;
    assign bus.s_valid   = s_valid_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

    // Stream FSM: start/config check, byte fetch on stream grant, drain, abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            remaining <= '0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (bus.abort) begin
                // abort beats everything, including a start in IDLE
                state     <= ST_IDLE;
                s_valid_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (!cfg_ok) begin
                                cfg_err_q <= 1'b1;
                            end else if (bus.length == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state     <= ST_RUN;
                                ptr       <= bus.base_addr;
                                remaining <= bus.length;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (grant_str) begin
                            s_data_q  <= bus.mem_rd[7:0];
                            s_valid_q <= 1'b1;
                            ptr       <= ptr + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == LEN_W'(1))
                                state <= ST_DRAIN;
                        end else if (bus.s_ready) begin
                            s_valid_q <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (s_valid_q && bus.s_ready) begin
                            s_valid_q <= 1'b0;
                            state     <= ST_IDLE;
                            done_q    <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
